sdes_round_ctrl: RTL

Iterative S-DES encrypt/decrypt engine controller. It accepts one 8-bit block and a 10-bit key over a valid/ready handshake. It time-shares a single F-function (EP, key XOR, S0/S1 S-boxes, P4) across both Feistel rounds and returns the result over a valid/ready handshake. It generates K1/K2 internally, sequences the rounds, and drives the S-box enables. It sits between the system block interface and the existing S0/S1 S-box instances (4-bit input, en, 2-bit out; out=0 when en=0).

---
 rtl/sdes_round_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sdes_round_ctrl.sv
// -----------------------------------------------------------------------------
// sdes_round_ctrl
//
// Iterative S-DES encrypt/decrypt engine. One 8-bit block and a 10-bit key are
// accepted over a valid/ready handshake. K1/K2 are derived at accept time. A
// single F-function (EP, key XOR, S0/S1, P4) is time-shared across both
// Feistel rounds, one round per clock. The result is held on a valid/ready
// output until the consumer takes it.
//
// Parameters
//   SBOX_GATE  1: S-box enable is high only while a round is being computed
//              0: S-box enable is tied high
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   block/key/mode present
//   in_ready   engine can accept (IDLE only)
//   din        plaintext (encrypt) or ciphertext (decrypt)
//   key        10-bit S-DES key
//   decrypt    0 = encrypt, 1 = decrypt; sampled at accept
//   out_valid  dout holds a completed result
//   out_ready  consumer takes the result
//   dout       result block; changes only when a result completes
//   busy       engine is not idle
// -----------------------------------------------------------------------------
module sdes_round_ctrl #(
    parameter logic SBOX_GATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] din,
    input  logic [9:0] key,
    input  logic       decrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] dout,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_R1   = 2'd1;
    localparam logic [1:0] ST_R2   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // S-box contents, indexed by {row, col} where row = {b3,b0} and
    // col = {b2,b1} of the raw 4-bit S-box input.
    localparam logic [1:0] S0_TBL [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };
    localparam logic [1:0] S1_TBL [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    // Permutations. Bit position 1 of the textbook tables is the MSB here.
    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    // P8 never selects the two most significant key bits, so it takes only
    // the low eight bits of the shifted key.
    function automatic logic [7:0] p8(input logic [7:0] y);
        return {y[4], y[7], y[3], y[6], y[2], y[5], y[0], y[1]};
    endfunction

    function automatic logic [4:0] rotl1(input logic [4:0] x);
        return {x[3:0], x[4]};
    endfunction

    function automatic logic [4:0] rotl2(input logic [4:0] x);
        return {x[2:0], x[4:3]};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] state;
    logic [3:0] l_q;
    logic [3:0] r_q;
    logic [7:0] k1_q;
    logic [7:0] k2_q;
    logic       mode_q;
    logic [7:0] dout_q;
    logic       out_valid_q;

    // ------------------------------------------------------------------------
    // Key schedule, evaluated on the live key so it can be captured at accept
    // ------------------------------------------------------------------------
    logic [9:0] key_p10;
    logic [4:0] ls1_hi;
    logic [4:0] ls1_lo;
    logic [4:0] ls2_lo;
    logic [2:0] ls2_hi_kept;
    logic [7:0] k1_next;
    logic [7:0] k2_next;

    assign key_p10 = p10(key);
    assign ls1_hi  = rotl1(key_p10[9:5]);
    assign ls1_lo  = rotl1(key_p10[4:0]);
    assign ls2_lo  = rotl2(ls1_lo);
    // Low three bits of LS-2 applied to the high half; the top two are
    // discarded by P8 anyway.
    assign ls2_hi_kept = {ls1_hi[0], ls1_hi[4:3]};
    assign k1_next = p8({ls1_hi[2:0], ls1_lo});
    assign k2_next = p8({ls2_hi_kept, ls2_lo});

    // ------------------------------------------------------------------------
    // Shared F-function
    // ------------------------------------------------------------------------
    logic       sbox_en;
    logic [7:0] round_key;
    logic [7:0] ep_x;
    logic [1:0] s0_out;
    logic [1:0] s1_out;
    logic [3:0] f_out;

    assign sbox_en = !SBOX_GATE || (state == ST_R1) || (state == ST_R2);

    // R1 uses K1 when encrypting and K2 when decrypting; R2 uses the other.
    assign round_key = ((state == ST_R1) ^ mode_q) ? k1_q : k2_q;
    assign ep_x      = ep(r_q) ^ round_key;

    // A disabled S-box drives zero, matching the S0/S1 instance behaviour.
    assign s0_out = sbox_en ? S0_TBL[{ep_x[7], ep_x[4], ep_x[6], ep_x[5]}] : 2'b00;
    assign s1_out = sbox_en ? S1_TBL[{ep_x[3], ep_x[0], ep_x[2], ep_x[1]}] : 2'b00;
    assign f_out  = p4({s0_out, s1_out});

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // NOTE: every register here is small flop state, so all of it is reset;
    // non-blocking assignments let R1 read old L/R while writing new ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            mode_q      <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip(din);
                        k1_q       <= k1_next;
                        k2_q       <= k2_next;
                        mode_q     <= decrypt;
                        state      <= ST_R1;
                    end
                end
                ST_R1: begin
                    // fk followed by SW in a single step.
                    l_q   <= r_q;
                    r_q   <= l_q ^ f_out;
                    state <= ST_R2;
                end
                ST_R2: begin
                    // Final fk has no swap; undo IP straight into dout.
                    dout_q      <= ip_inv({l_q ^ f_out, r_q});
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule
